pong_game_fsm: RTL and testbench
================================

PONG_GAME_FSM -- requirements
Module: pong_game_fsm

Interface
REQ-001 The block SHALL have parameter DISP_COLS, default 800, meaning the first non-visible column index.
REQ-002 The block SHALL have parameter DISP_ROWS, default 600, meaning the first non-visible row index.
REQ-003 The block SHALL have parameter SCORE_LIMIT, default 5, meaning points to win (1..15).
REQ-004 The block SHALL have parameter SERVE_FRAMES, default 60, meaning frames the ball is held centred before play.
REQ-005 The block SHALL have parameter POINT_FRAMES, default 120, meaning frames of pause after a point.
REQ-006 The block SHALL have the following ports. Clock and reset are fixed: one clock; reset is asynchronous and active-low.
  - clk  in  1  system/pixel clock
  - rst_n  in  1  asynchronous active-low reset
  - col_counter  in  12  current column from sync counter
  - row_counter  in  12  current row from sync counter
  - start  in  1  start button, level, synchronous to clk
  - miss_p0  in  1  ball passed left edge (p1 scores), level
  - miss_p1  in  1  ball passed right edge (p0 scores), level
  - game_state  out  3  encoded current state
  - ball_enable  out  1  ball may move
  - ball_center  out  1  ball held at screen centre
  - paddle_enable  out  1  paddles respond to controls
  - serve_dir  out  1  0 = serve toward p0 (left), 1 = toward p1 (right)
  - score_p0  out  4  player 0 score
  - score_p1  out  4  player 1 score
  - winner  out  1  0 = p0, 1 = p1; valid only in GAME_OVER

Function
REQ-007 frame_tick SHALL be an internal one-cycle pulse, asserted when col_counter==DISP_COLS and row_counter==DISP_ROWS.
REQ-008 start SHALL be rising-edge detected with a registered previous value; a held button yields exactly one event.
REQ-009 The states SHALL be IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4, and every output SHALL be registered.
REQ-010 In IDLE: ball_center=1, ball_enable=0, paddle_enable=0. A start edge SHALL clear both scores, set serve_dir=1 and go to SERVE.
REQ-011 In SERVE: ball_center=1, paddle_enable=1. After SERVE_FRAMES frame_ticks counted in SERVE, the block SHALL go to PLAY on the cycle after the last tick.
REQ-012 In PLAY: ball_enable=1, ball_center=0, paddle_enable=1. miss_p0 SHALL increment score_p1; miss_p1 SHALL increment score_p0. Either SHALL cause a transition to POINT on the next edge.
REQ-013 Simultaneous miss_p0 and miss_p1 in PLAY SHALL change no score, leave serve_dir unchanged and go to POINT (replay).
REQ-014 On a single miss, serve_dir SHALL be set toward the player who conceded: miss_p0 gives 0, miss_p1 gives 1.
REQ-015 miss_p0 and miss_p1 SHALL be ignored outside PLAY. A miss level held through POINT/SERVE SHALL NOT score again.
REQ-016 In POINT: ball_enable=0, paddle_enable=1. After POINT_FRAMES frame_ticks the block SHALL go to GAME_OVER if either score == SCORE_LIMIT, else to SERVE.
REQ-017 In GAME_OVER: ball_enable=0, ball_center=1, paddle_enable=0. winner SHALL be latched on entry. A start edge SHALL clear scores, set serve_dir=1 and go to SERVE.
REQ-018 Scores SHALL saturate at SCORE_LIMIT and never wrap.
REQ-019 The frame counter SHALL be $clog2(max(SERVE_FRAMES,POINT_FRAMES)+1) bits wide and SHALL clear on every state change.
REQ-020 A start edge in SERVE, PLAY or POINT SHALL be ignored.

Reset
REQ-021 While rst_n=0, the block SHALL hold: state IDLE, score_p0=score_p1=0, serve_dir=1, winner=0, ball_center=1, ball_enable=0, paddle_enable=0, frame counter=0, start-edge register=0.
REQ-022 Reset asserted mid-game SHALL abandon the game immediately, asynchronously. Release SHALL take effect on the next clk edge.

Structure
REQ-023 State encoding constants and the score width SHALL reside in the shared package pong_pkg.
REQ-024 One sub-module, pong_frame_timer, SHALL be used: frame_tick generation plus the load/count/done frame counter. The FSM SHALL remain in pong_game_fsm.

Verification
REQ-025 Reset then start pulse: IDLE -> SERVE, then PLAY exactly 60 frame_ticks later, with ball_enable=1.
REQ-026 In PLAY, a 1-cycle miss_p1: score_p0=1, serve_dir=1, POINT. After 120 ticks: SERVE.
REQ-027 miss_p0 and miss_p1 asserted in the same cycle: scores unchanged, POINT, serve_dir unchanged.
REQ-028 p1 scores 5 times: GAME_OVER, winner=1, score_p1=5. A start edge then gives SERVE with both scores 0.
REQ-029 rst_n pulsed low in PLAY with score 3-2: immediate IDLE, scores 0, ball_center=1.
REQ-030 start held high for 1000 cycles in IDLE: exactly one transition. miss held high across POINT/SERVE: only one point scored.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller.
// State encodings are fixed because game_state is visible outside the block.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_game_fsm_if.sv
// Control/status bundle between the raster/ball logic and the game controller.
// The slave modport is the controller's view.
interface pong_game_fsm_if;
  import pong_pkg::*;

  logic [11:0]        col_counter;
  logic [11:0]        row_counter;
  logic               start;
  logic               miss_p0;
  logic               miss_p1;
  logic [STATE_W-1:0] game_state;
  logic               ball_enable;
  logic               ball_center;
  logic               paddle_enable;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_p0;
  logic [SCORE_W-1:0] score_p1;
  logic               winner;

  modport slave (
    input  col_counter, row_counter, start, miss_p0, miss_p1,
    output game_state, ball_enable, ball_center, paddle_enable,
           serve_dir, score_p0, score_p1, winner
  );

  modport master (
    output col_counter, row_counter, start, miss_p0, miss_p1,
    input  game_state, ball_enable, ball_center, paddle_enable,
           serve_dir, score_p0, score_p1, winner
  );

endinterface

// File: rtl/pong_frame_timer.sv
// Frame tick decode plus a frame counter that reports when the selected
// hold length (serve or point pause) has elapsed.
module pong_frame_timer #(
  parameter int DISP_COLS    = 800,
  parameter int DISP_ROWS    = 600,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 120,
  parameter int CNT_W        = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] col_counter,
  input  logic [11:0] row_counter,
  input  logic        clear,
  input  logic        count_en,
  input  logic        sel_point,
  output logic        done
);

  logic             frame_tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit;

  assign frame_tick = (col_counter == 12'(DISP_COLS)) && (row_counter == 12'(DISP_ROWS));
  assign limit      = sel_point ? CNT_W'(POINT_FRAMES - 1) : CNT_W'(SERVE_FRAMES - 1);
  // done fires on the last counted tick so the FSM moves on the following cycle
  assign done       = count_en && frame_tick && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && frame_tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_game_fsm.sv
// Pong game sequencer: serve hold, play, point pause, scoring and game over.
// All outputs come straight from flops.
module pong_game_fsm
  import pong_pkg::*;
#(
  parameter int DISP_COLS    = 800,
  parameter int DISP_ROWS    = 600,
  parameter int SCORE_LIMIT  = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 120
) (
  input  logic            clk,
  input  logic            rst_n,
  pong_game_fsm_if.slave  bus
);

  localparam int CNT_W = $clog2(max2(SERVE_FRAMES, POINT_FRAMES) + 1);
  localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(SCORE_LIMIT);

  state_t             state_q, state_d;
  logic               start_q;
  logic [SCORE_W-1:0] score_p0_q, score_p0_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               ball_enable_q, ball_enable_d;
  logic               ball_center_q, ball_center_d;
  logic               paddle_enable_q, paddle_enable_d;
  logic               start_edge;
  logic               timer_done;

  assign start_edge = bus.start && !start_q;

  pong_frame_timer #(
    .DISP_COLS    (DISP_COLS),
    .DISP_ROWS    (DISP_ROWS),
    .SERVE_FRAMES (SERVE_FRAMES),
    .POINT_FRAMES (POINT_FRAMES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_counter (bus.col_counter),
    .row_counter (bus.row_counter),
    .clear       (state_d != state_q),
    .count_en    ((state_q == ST_SERVE) || (state_q == ST_POINT)),
    .sel_point   (state_q == ST_POINT),
    .done        (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    score_p0_d  = score_p0_q;
    score_p1_d  = score_p1_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          score_p0_d  = '0;
          score_p1_d  = '0;
          serve_dir_d = 1'b1;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (timer_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // a double miss is a replay: no score, serve direction kept
        if (bus.miss_p0 && bus.miss_p1) begin
          state_d = ST_POINT;
        end else if (bus.miss_p0) begin
          if (score_p1_q < LIMIT) score_p1_d = score_p1_q + 1'b1;
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
        end else if (bus.miss_p1) begin
          if (score_p0_q < LIMIT) score_p0_d = score_p0_q + 1'b1;
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
        end
      end
      ST_POINT: begin
        if (timer_done) begin
          if ((score_p0_q == LIMIT) || (score_p1_q == LIMIT)) begin
            winner_d = (score_p1_q == LIMIT);
            state_d  = ST_GAME_OVER;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ball_enable_d   = (state_d == ST_PLAY);
    ball_center_d   = (state_d != ST_PLAY);
    paddle_enable_d = (state_d == ST_SERVE) || (state_d == ST_PLAY) || (state_d == ST_POINT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      start_q         <= 1'b0;
      score_p0_q      <= '0;
      score_p1_q      <= '0;
      serve_dir_q     <= 1'b1;
      winner_q        <= 1'b0;
      ball_enable_q   <= 1'b0;
      ball_center_q   <= 1'b1;
      paddle_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_q         <= bus.start;
      score_p0_q      <= score_p0_d;
      score_p1_q      <= score_p1_d;
      serve_dir_q     <= serve_dir_d;
      winner_q        <= winner_d;
      ball_enable_q   <= ball_enable_d;
      ball_center_q   <= ball_center_d;
      paddle_enable_q <= paddle_enable_d;
    end
  end

  assign bus.game_state    = state_q;
  assign bus.ball_enable   = ball_enable_q;
  assign bus.ball_center   = ball_center_q;
  assign bus.paddle_enable = paddle_enable_q;
  assign bus.serve_dir     = serve_dir_q;
  assign bus.score_p0      = score_p0_q;
  assign bus.score_p1      = score_p1_q;
  assign bus.winner        = winner_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Bench for pong_game_fsm: opening vector table, then hand-written game
// sequences; expected states are queued and compared on the falling edge.
module tb_pong_game_fsm;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pong_game_fsm_if bus_if ();

  pong_game_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        be, bc, pe, dir;
    int          s0, s1;
    logic        chk_bc;
    logic        chk_win;
    logic        win;
  } exp_t;

  typedef struct {
    logic       st, m0, m1, tk;
    logic [2:0] e_st;
    logic       e_dir;
    int         e_s0, e_s1;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.tag, " state"}, int'(bus_if.game_state), int'(e.st));
    chk({e.tag, " ball_enable"}, int'(bus_if.ball_enable), int'(e.be));
    if (e.chk_bc) chk({e.tag, " ball_center"}, int'(bus_if.ball_center), int'(e.bc));
    chk({e.tag, " paddle_enable"}, int'(bus_if.paddle_enable), int'(e.pe));
    chk({e.tag, " serve_dir"}, int'(bus_if.serve_dir), int'(e.dir));
    chk({e.tag, " score_p0"}, int'(bus_if.score_p0), e.s0);
    chk({e.tag, " score_p1"}, int'(bus_if.score_p1), e.s1);
    if (e.chk_win) chk({e.tag, " winner"}, int'(bus_if.winner), int'(e.win));
  endtask

  // Output decode expected in each state
  function automatic exp_t mk(input string tag, input logic [2:0] st, input logic dir,
                              input int s0, input int s1);
    exp_t e;
    e.tag = tag; e.st = st; e.dir = dir; e.s0 = s0; e.s1 = s1;
    e.chk_bc = 1'b1; e.chk_win = 1'b0; e.win = 1'b0;
    case (st)
      ST_PLAY:  begin e.be = 1'b1; e.bc = 1'b0; e.pe = 1'b1; end
      ST_SERVE: begin e.be = 1'b0; e.bc = 1'b1; e.pe = 1'b1; end
      ST_POINT: begin e.be = 1'b0; e.bc = 1'b1; e.pe = 1'b1; e.chk_bc = 1'b0; end
      default:  begin e.be = 1'b0; e.bc = 1'b1; e.pe = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic expect_st(input string tag, input logic [2:0] st, input logic dir,
                           input int s0, input int s1);
    sb_q.push_back(mk(tag, st, dir, s0, s1));
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) compare(sb_q.pop_front());
  end

  task automatic cyc(input logic st, input logic m0, input logic m1, input logic tk);
    bus_if.start       = st;
    bus_if.miss_p0     = m0;
    bus_if.miss_p1     = m1;
    bus_if.col_counter = tk ? 12'd800 : 12'd0;
    bus_if.row_counter = tk ? 12'd600 : 12'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input logic m0, input logic m1);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, m0, m1, 1'b1);
      cyc(1'b0, m0, m1, 1'b0);
    end
  endtask

  vec_t vecs[9];
  exp_t e;
  int   trans;
  logic [2:0] prev_st;
  logic       pts_m1[5];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,  1'b1, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,  1'b1, 0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_IDLE,  1'b1, 0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_SERVE, 1'b1, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_SERVE, 1'b1, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_SERVE, 1'b1, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_SERVE, 1'b1, 0, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, ST_SERVE, 1'b1, 0, 0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_SERVE, 1'b1, 0, 0};

    rst_n = 1'b0;
    bus_if.start = 1'b0; bus_if.miss_p0 = 1'b0; bus_if.miss_p1 = 1'b0;
    bus_if.col_counter = 12'd0; bus_if.row_counter = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    e = mk("reset", ST_IDLE, 1'b1, 0, 0);
    e.chk_win = 1'b1; e.win = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].st, vecs[i].m0, vecs[i].m1, vecs[i].tk);
      expect_st($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_dir, vecs[i].e_s0, vecs[i].e_s1);
    end

    ticks(59, 1'b0, 1'b0);
    expect_st("serve 59 ticks", ST_SERVE, 1'b1, 0, 0);
    ticks(1, 1'b0, 1'b0);
    expect_st("serve 60 ticks", ST_PLAY, 1'b1, 0, 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("start in play", ST_PLAY, 1'b1, 0, 0);
    ticks(5, 1'b0, 1'b0);
    expect_st("ticks in play", ST_PLAY, 1'b1, 0, 0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("miss_p1", ST_POINT, 1'b1, 1, 0);
    ticks(119, 1'b0, 1'b0);
    expect_st("point 119 ticks", ST_POINT, 1'b1, 1, 0);
    ticks(1, 1'b0, 1'b0);
    expect_st("point 120 ticks", ST_SERVE, 1'b1, 1, 0);
    ticks(60, 1'b0, 1'b0);
    expect_st("replay serve", ST_PLAY, 1'b1, 1, 0);

    // miss_p0 held high across the whole pause and most of the serve
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("miss_p0", ST_POINT, 1'b0, 1, 1);
    ticks(120, 1'b1, 1'b0);
    expect_st("held miss point", ST_SERVE, 1'b0, 1, 1);
    ticks(59, 1'b1, 1'b0);
    expect_st("held miss serve", ST_SERVE, 1'b0, 1, 1);
    ticks(1, 1'b0, 1'b0);
    expect_st("held miss play", ST_PLAY, 1'b0, 1, 1);

    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    expect_st("double miss", ST_POINT, 1'b0, 1, 1);
    ticks(120, 1'b0, 1'b0);
    ticks(60, 1'b0, 1'b0);
    expect_st("after double miss", ST_PLAY, 1'b0, 1, 1);

    for (int k = 2; k <= 5; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_st($sformatf("p1 point %0d", k), ST_POINT, 1'b0, 1, k);
      ticks(120, 1'b0, 1'b0);
      if (k < 5) begin
        expect_st($sformatf("p1 serve %0d", k), ST_SERVE, 1'b0, 1, k);
        ticks(60, 1'b0, 1'b0);
      end
    end
    e = mk("game over", ST_GAME_OVER, 1'b0, 1, 5);
    e.chk_win = 1'b1; e.win = 1'b1;
    sb_q.push_back(e);

    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    e = mk("game over idle", ST_GAME_OVER, 1'b0, 1, 5);
    e.chk_win = 1'b1; e.win = 1'b1;
    sb_q.push_back(e);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("restart", ST_SERVE, 1'b1, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(60, 1'b0, 1'b0);
    expect_st("restart play", ST_PLAY, 1'b1, 0, 0);

    pts_m1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, !pts_m1[k], pts_m1[k], 1'b0);
      ticks(120, 1'b0, 1'b0);
      ticks(60, 1'b0, 1'b0);
    end
    expect_st("score 3-2", ST_PLAY, 1'b0, 3, 2);
    @(negedge clk);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    e = mk("async reset", ST_IDLE, 1'b1, 0, 0);
    e.chk_win = 1'b1; e.win = 1'b0;
    compare(e);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("after reset release", ST_IDLE, 1'b1, 0, 0);

    trans = 0;
    for (int i = 0; i < 1000; i++) begin
      prev_st = bus_if.game_state;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus_if.game_state != prev_st) trans++;
    end
    chk("start held transitions", trans, 1);
    expect_st("start held", ST_SERVE, 1'b1, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
